// File: rtl/add_n_bits_pkg.sv
// Shared constants for the add_n_bits ripple-carry adder.
// ADD_N_DEFAULT is the operand MSB index, giving 33-bit operands.
package add_n_bits_pkg;

    localparam int ADD_N_DEFAULT = 32;

endpackage

// File: rtl/add_n_bits_full_adder.sv
// Single-bit full adder cell; one link of the ripple-carry chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/add_n_bits.sv
// (N+1)-bit ripple-carry adder with carry-in.
// The sum and carry-out are registered, so the result appears one cycle after the operands.
module add_n_bits
    import add_n_bits_pkg::*;
#(
    parameter int N = ADD_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N:0]   x,
    input  logic [N:0]   y,
    input  logic         cin,
    output logic [N:0]   z,
    output logic         cout
);

    logic [N+1:0] c;
    logic [N:0]   s;

    logic [N:0]   z_d, z_q;
    logic         cout_d, cout_q;

    assign c[0] = cin;

    // Carry ripples from bit 0 to bit N; no lookahead by design.
    for (genvar i = 0; i <= N; i++) begin : g_fa
        full_adder u_fa (
            .a  (x[i]),
            .b  (y[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    always_comb begin
        z_d    = s;
        cout_d = c[N+1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            z_q    <= z_d;
            cout_q <= cout_d;
        end
    end

    assign z    = z_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_add_n_bits.sv
// Directed, table-driven and random checks for add_n_bits at N = 32.
module tb_add_n_bits;

    localparam int N = 32;
    localparam logic [N:0] ALL1 = {(N+1){1'b1}};

    typedef struct {
        string      name;
        logic [N:0] x;
        logic [N:0] y;
        logic       cin;
        logic [N:0] ez;
        logic       ec;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [N:0]   x = '0;
    logic [N:0]   y = '0;
    logic         cin = 1'b0;
    logic [N:0]   z;
    logic         cout;

    int total = 0;
    int bad   = 0;
    vec_t vecs[$];

    add_n_bits #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y),
        .cin   (cin),
        .z     (z),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N:0] ez, input logic ec);
        total++;
        if ({cout, z} !== {ec, ez}) begin
            bad++;
            $display("FAIL %s: got cout=%0d z=0x%0h, expected cout=%0d z=0x%0h",
                     name, cout, z, ec, ez);
        end
    endtask

    task automatic add_vec(input string name, input logic [N:0] vx, input logic [N:0] vy,
                           input logic vc, input logic [N:0] ez, input logic ec);
        vec_t v;
        v.name = name; v.x = vx; v.y = vy; v.cin = vc; v.ez = ez; v.ec = ec;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [N:0] vx, input logic [N:0] vy, input logic vc);
        x = vx; y = vy; cin = vc;
    endtask

    initial begin
        add_vec("two_plus_two",   33'd2,   33'd2,   1'b0, 33'd4,   1'b0);
        add_vec("ff_plus_ff",     33'd255, 33'd255, 1'b0, 33'd510, 1'b0);
        add_vec("ff_plus_ff_cin", 33'd255, 33'd255, 1'b1, 33'd511, 1'b0);
        add_vec("full_ripple",    ALL1,    33'd0,   1'b1, 33'd0,   1'b1);
        add_vec("max_sum",        ALL1,    ALL1,    1'b1, ALL1,    1'b1);
        add_vec("ones_no_cin",    ALL1,    ALL1,    1'b0, {ALL1[N:1], 1'b0}, 1'b1);
        add_vec("zero",           33'd0,   33'd0,   1'b0, 33'd0,   1'b0);

        // Asynchronous reset with arbitrary inputs, before any clock edge
        drive(33'h1_2345_6789, 33'h0_DEAD_BEEF, 1'b1);
        #1 rst_n = 1'b0;
        #1 check("reset_async", 33'd0, 1'b0);
        @(posedge clk); #1 check("reset_held", 33'd0, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // Table: hold each vector for two cycles
        foreach (vecs[i]) begin
            @(negedge clk) drive(vecs[i].x, vecs[i].y, vecs[i].cin);
            @(posedge clk); #1 check(vecs[i].name, vecs[i].ez, vecs[i].ec);
            @(posedge clk); #1 check({vecs[i].name, "_hold"}, vecs[i].ez, vecs[i].ec);
        end

        // Latency: a change half a cycle before an edge shows only after that edge
        @(negedge clk) drive(33'd2, 33'd2, 1'b0);
        @(posedge clk); #1 check("lat_first", 33'd4, 1'b0);
        @(negedge clk) drive(33'd255, 33'd255, 1'b0);
        #1 check("lat_between_edges", 33'd4, 1'b0);
        @(posedge clk); #1 check("lat_after_edge", 33'd510, 1'b0);

        // Reset mid-stream clears at once and does not replay
        @(negedge clk); #2 rst_n = 1'b0;
        #1 check("midreset_clear", 33'd0, 1'b0);
        drive(33'd1, 33'd1, 1'b0);
        @(posedge clk); #1 check("midreset_held", 33'd0, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1 check("midreset_release", 33'd2, 1'b0);

        // Random vectors against a 34-bit reference sum
        for (int i = 0; i < 1000; i++) begin
            logic [N:0]   rx, ry;
            logic         rc;
            logic [N+1:0] ref_sum;
            bit           bx, by;
            bx = 1'($urandom_range(0, 1));
            by = 1'($urandom_range(0, 1));
            rx = {bx, 32'($urandom())};
            ry = {by, 32'($urandom())};
            rc = 1'($urandom_range(0, 1));
            ref_sum = {1'b0, rx} + {1'b0, ry} + {{(N+1){1'b0}}, rc};
            @(negedge clk) drive(rx, ry, rc);
            @(posedge clk); #1 check("random", ref_sum[N:0], ref_sum[N+1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
